stopwatch_time_counter: RTL and testbench

- Produces the BCD seconds digits n1/n0 (00-59) that feed the 16-LED animator, plus BCD minute digits m1/m0 for the 7-segment display.
- Debounces the start/stop, lap and clear buttons and runs the run/pause/idle control FSM.
- Prescales the board clock to a 1 Hz tick and advances a 00:00-59:59 BCD counter on each tick.
- Sits between the button pins and the display/LED blocks.

---
 rtl/stopwatch_time_counter.sv | 205 ++++++++++++++++++++
 tb/tb_stopwatch_time_counter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_counter.sv
// Stopwatch core: debounces three buttons, runs the IDLE/RUN/PAUSE control FSM,
// prescales clk to a 1 Hz tick and keeps a 00:00-59:59 BCD count with a lap freeze.
module stopwatch_time_counter #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] n0,
  output logic [3:0] n1,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic       running,
  output logic       lap_active,
  output logic       sec_tick,
  output logic       wrap
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Button index: 0 = start/stop, 1 = lap, 2 = clear
  logic [2:0] raw;
  logic [2:0] pulse;
  logic       ss_p;
  logic       lap_p;
  logic       clr_p;

  assign raw   = {btn_clear, btn_lap, btn_start_stop};
  assign ss_p  = pulse[0];
  assign lap_p = pulse[1];
  assign clr_p = pulse[2];

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic          s1;
    logic          s2;
    logic          level;
    logic          pls;
    logic [DW-1:0] cnt;

    // Level flips only after DB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        level <= 1'b0;
        pls   <= 1'b0;
        cnt   <= '0;
      end else begin
        s1  <= raw[i];
        s2  <= s1;
        pls <= 1'b0;
        if (s2 == level) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          level <= s2;
          pls   <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign pulse[i] = pls;
  end

  state_t state;
  state_t state_next;
  logic   count_en;
  logic   clear_all;
  logic   lap_toggle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
    end
  end

  // Clear beats start/stop in PAUSE; clear is ignored in IDLE and RUN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ss_p) state_next = RUN;
      RUN:     if (ss_p) state_next = PAUSE;
      PAUSE: begin
        if (clr_p)     state_next = IDLE;
        else if (ss_p) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_en   = 1'b0;
    clear_all  = 1'b0;
    lap_toggle = 1'b0;
    case (state)
      RUN: begin
        count_en   = 1'b1;
        lap_toggle = lap_p;
      end
      PAUSE:   clear_all = clr_p;
      default: ;
    endcase
  end

  logic [PW-1:0] presc;
  logic          terminal;
  logic [3:0]    sec0;
  logic [3:0]    sec1;
  logic [3:0]    min0;
  logic [3:0]    min1;
  logic [15:0]   live;
  logic [15:0]   lap_snap;
  logic          at_max;

  assign terminal = count_en && (presc == PRESC_LAST);
  assign live     = {min1, min0, sec1, sec0};
  assign at_max   = (live == 16'h5959);

  // Prescaler holds in PAUSE so a resume finishes the partial second.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (clear_all) begin
      presc <= '0;
    end else if (count_en) begin
      presc <= terminal ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec0     <= 4'd0;
      sec1     <= 4'd0;
      min0     <= 4'd0;
      min1     <= 4'd0;
      sec_tick <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      sec_tick <= terminal;
      wrap     <= terminal && at_max;
      if (clear_all) begin
        sec0 <= 4'd0;
        sec1 <= 4'd0;
        min0 <= 4'd0;
        min1 <= 4'd0;
      end else if (terminal) begin
        if (sec0 != 4'd9) begin
          sec0 <= sec0 + 4'd1;
        end else begin
          sec0 <= 4'd0;
          if (sec1 != 4'd5) begin
            sec1 <= sec1 + 4'd1;
          end else begin
            sec1 <= 4'd0;
            if (min0 != 4'd9) begin
              min0 <= min0 + 4'd1;
            end else begin
              min0 <= 4'd0;
              min1 <= (min1 == 4'd5) ? 4'd0 : min1 + 4'd1;
            end
          end
        end
      end
    end
  end

  // Snapshot takes the pre-increment count when it lands on a tick edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_snap   <= 16'h0000;
      lap_active <= 1'b0;
    end else if (clear_all) begin
      lap_snap   <= 16'h0000;
      lap_active <= 1'b0;
    end else if (lap_toggle) begin
      if (!lap_active) begin
        lap_snap   <= live;
        lap_active <= 1'b1;
      end else begin
        lap_active <= 1'b0;
      end
    end
  end

  assign {m1, m0, n1, n0} = lap_active ? lap_snap : live;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: directed vector table, hand sequences for
// bounce / 12:34 async reset / rollover, and random button traffic against a model.
module tb_stopwatch_time_counter;

  localparam int TICK = 4;
  localparam int DB   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] n0, n1, m0, m1;
  logic       running, lap_active, sec_tick, wrap;
  logic [15:0] disp;

  assign disp = {m1, m0, n1, n0};

  always #5 clk = ~clk;

  stopwatch_time_counter #(
    .TICK_CYCLES(TICK),
    .DB_CYCLES  (DB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_start_stop(btn_start_stop),
    .btn_lap       (btn_lap),
    .btn_clear     (btn_clear),
    .n0            (n0),
    .n1            (n1),
    .m0            (m0),
    .m1            (m1),
    .running       (running),
    .lap_active    (lap_active),
    .sec_tick      (sec_tick),
    .wrap          (wrap)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int mm;
    int ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // ---------------- reference model (whole seconds, button history windows)
  int          m_state;   // 0 idle, 1 run, 2 pause
  int          m_presc;
  int          m_secs;
  int          m_lsecs;
  bit          m_lap, m_tick, m_wrap;
  bit [2:0]    m_lvl, m_pulse, m_s1, m_s2;
  logic [DB-1:0] m_win [3];

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_secs = 0; m_lsecs = 0;
    m_lap = 0; m_tick = 0; m_wrap = 0;
    m_lvl = '0; m_pulse = '0; m_s1 = '0; m_s2 = '0;
    for (int b = 0; b < 3; b++) m_win[b] = '0;
  endtask

  task automatic model_step(input logic [2:0] rawv);
    bit [2:0] newp;
    bit       ss, lp, cl, term;
    newp = '0;
    for (int b = 0; b < 3; b++) begin
      m_win[b] = {m_win[b][DB-2:0], m_s2[b]};
      if (m_win[b] == (m_lvl[b] ? {DB{1'b0}} : {DB{1'b1}})) begin
        m_lvl[b] = ~m_lvl[b];
        newp[b]  = m_lvl[b];
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = rawv[b];
    end
    ss = m_pulse[0]; lp = m_pulse[1]; cl = m_pulse[2];
    term   = (m_state == 1) && (m_presc == TICK - 1);
    m_tick = term;
    m_wrap = term && (m_secs == 3599);
    if (m_state == 1 && lp) begin
      if (!m_lap) begin m_lsecs = m_secs; m_lap = 1; end
      else m_lap = 0;
    end
    if (m_state == 1) begin
      m_presc = term ? 0 : m_presc + 1;
      if (term) m_secs = (m_secs + 1) % 3600;
    end
    case (m_state)
      0: if (ss) m_state = 1;
      1: if (ss) m_state = 2;
      default: begin
        if (cl) begin
          m_state = 0; m_presc = 0; m_secs = 0; m_lsecs = 0; m_lap = 0;
        end else if (ss) m_state = 1;
      end
    endcase
    m_pulse = newp;
  endtask

  logic [2:0] smp_btn;
  logic       smp_rst;
  always @(posedge clk) begin
    smp_btn <= {btn_clear, btn_lap, btn_start_stop};
    smp_rst <= reset;
  end

  always @(negedge clk) begin
    if (smp_rst) model_reset();
    else model_step(smp_btn);
    check("disp", disp, m_lap ? to_bcd(m_lsecs) : to_bcd(m_secs));
    check("running", running, m_state == 1);
    check("lap_active", lap_active, m_lap);
    check("tick_wrap", {sec_tick, wrap}, {m_tick, m_wrap});
  end

  // ---------------- drivers
  task automatic set_btns(input logic [2:0] v);
    btn_start_stop = v[0];
    btn_lap        = v[1];
    btn_clear      = v[2];
  endtask

  task automatic press(input logic [2:0] mask, input int hold, input int gap);
    set_btns(mask);
    repeat (hold) @(negedge clk);
    set_btns(3'b000);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_btns(3'b000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    int budget;
    seen   = 0;
    budget = n * TICK + 64;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (sec_tick) seen++;
    end
    check("tick_budget", seen, n);
  endtask

  typedef struct {
    logic [2:0] btn;
    logic       exp_run;
    logic       exp_lap;
    int         exp_secs;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Each press: 5 cycles held, 10 released; action lands 5 edges after it starts.
    vecs[0]  = '{3'b001, 1'b1, 1'b0, 2};   // start
    vecs[1]  = '{3'b010, 1'b1, 1'b1, 3};   // lap freeze at 00:03
    vecs[2]  = '{3'b010, 1'b1, 1'b0, 9};   // lap release
    vecs[3]  = '{3'b001, 1'b0, 1'b0, 11};  // pause
    vecs[4]  = '{3'b100, 1'b0, 1'b0, 0};   // clear in pause
    vecs[5]  = '{3'b001, 1'b1, 1'b0, 2};   // start again
    vecs[6]  = '{3'b100, 1'b1, 1'b0, 6};   // clear in run ignored
    vecs[7]  = '{3'b010, 1'b1, 1'b1, 7};   // lap at 00:07
    vecs[8]  = '{3'b001, 1'b0, 1'b1, 7};   // pause keeps lap
    vecs[9]  = '{3'b010, 1'b0, 1'b1, 7};   // lap in pause ignored
    vecs[10] = '{3'b001, 1'b1, 1'b1, 7};   // resume, still frozen
    vecs[11] = '{3'b010, 1'b1, 1'b0, 17};  // lap release shows live
    vecs[12] = '{3'b001, 1'b0, 1'b0, 18};  // pause
    vecs[13] = '{3'b101, 1'b0, 1'b0, 0};   // start+clear in pause: clear wins
    vecs[14] = '{3'b101, 1'b1, 1'b0, 2};   // start+clear in idle: start wins

    // Bounce rejection, then one clean press
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_start_stop = ~btn_start_stop;
      repeat (2) @(negedge clk);
    end
    btn_start_stop = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_running", running, 1'b0);
    check("bounce_disp", disp, 16'h0000);
    press(3'b001, 5, 10);
    check("clean_press_running", running, 1'b1);
    repeat (30) @(negedge clk);
    check("single_pulse_running", running, 1'b1);
    check("single_pulse_count", disp, to_bcd(9));

    // Directed vector table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      press(vecs[i].btn, 5, 10);
      check($sformatf("vec%0d_running", i), running, vecs[i].exp_run);
      check($sformatf("vec%0d_lap", i), lap_active, vecs[i].exp_lap);
      check($sformatf("vec%0d_disp", i), disp, to_bcd(vecs[i].exp_secs));
    end

    // Async reset at 12:34 with no clock edge
    do_reset();
    press(3'b001, 5, 0);
    wait_ticks(754);
    check("disp_1234", disp, 16'h1234);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs",
             {n0, n1, m0, m1, running, lap_active, sec_tick, wrap}, 20'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Rollover 59:59 -> 00:00 from a fresh start
    press(3'b001, 5, 0);
    wait_ticks(3599);
    check("disp_5959", disp, 16'h5959);
    check("wrap_low_5959", wrap, 1'b0);
    wait_ticks(1);
    check("rollover_disp", disp, 16'h0000);
    check("rollover_wrap", {sec_tick, wrap}, 2'b11);

    // Random button traffic, with bounce and occasional mid-cycle resets
    do_reset();
    for (int it = 0; it < 200; it++) begin
      logic [2:0] mask;
      mask = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
          set_btns(mask);
          repeat ($urandom_range(1, 2)) @(negedge clk);
          set_btns(3'b000);
          repeat ($urandom_range(1, 2)) @(negedge clk);
        end
      end else begin
        press(mask, $urandom_range(1, 7), $urandom_range(0, 12));
      end
      if ($urandom_range(0, 49) == 0) begin
        #3 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
